// File: rtl/regfile_8x64_rd_pkg.sv
// cpu_defs: register-file geometry shared by the ID/EX operand logic
package cpu_defs;
  localparam int REG_AW = 3;
  localparam int REG_N = 8;
  localparam int DW = 64;
  typedef logic [REG_AW-1:0] reg_addr_t;
  localparam reg_addr_t REG_ZERO = 3'd0;
endpackage

// File: rtl/regfile_8x64_rd_mux.sv
// mux8_to_1_x64: selects one of eight data words by register address
module mux8_to_1_x64
  import cpu_defs::*;
#(
  parameter int W = 64
) (
  input  logic [REG_N-1:0][W-1:0] d,
  input  reg_addr_t               sel,
  output logic [W-1:0]            q
);
  assign q = d[sel];
endmodule

// File: rtl/regfile_8x64_rd.sv
// regfile_8x64_rd: 8x64 register file with bypassed, registered read ports and debug readback
module regfile_8x64_rd
  import cpu_defs::*;
#(
  parameter int DW = cpu_defs::DW,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          WE,
  input  reg_addr_t     WA,
  input  logic [DW-1:0] WD,
  input  logic          RE,
  input  reg_addr_t     RA0,
  input  reg_addr_t     RA1,
  input  logic          STALL,
  input  logic          FLUSH,
  output logic [DW-1:0] Q0,
  output logic [DW-1:0] Q1,
  output logic          QV,
  input  reg_addr_t     DBG_A,
  output logic [DW-1:0] DBG_Q
);
  logic [REG_N-1:0][DW-1:0] regs, byp;
  logic [DW-1:0] rd_a, rd_b;
  logic wr_ok;
  assign wr_ok = WE && !(ZERO_R0 && WA == REG_ZERO);
  // storage: r0 never takes a write when hardwired, so raw storage already reads zero there
  always_ff @(posedge clk or posedge reset)
    if (reset) regs <= '0;
    else if (wr_ok) regs[WA] <= WD;
  // read view of the array with this edge's write forwarded in
  always_comb
    for (int i = 0; i < REG_N; i++)
      byp[i] = (ZERO_R0 && reg_addr_t'(i) == REG_ZERO) ? '0 :
               (WE && WA == reg_addr_t'(i)) ? WD : regs[i];
  mux8_to_1_x64 #(.W(DW)) u_mux_a (.d(byp), .sel(RA0), .q(rd_a));
  mux8_to_1_x64 #(.W(DW)) u_mux_b (.d(byp), .sel(RA1), .q(rd_b));
  mux8_to_1_x64 #(.W(DW)) u_mux_dbg (.d(regs), .sel(DBG_A), .q(DBG_Q));
  // operand capture: flush squashes, stall holds everything, idle drops valid only
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      Q0 <= '0;
      Q1 <= '0;
      QV <= 1'b0;
    end else if (FLUSH) begin
      Q0 <= '0;
      Q1 <= '0;
      QV <= 1'b0;
    end else if (!STALL) begin
      if (RE) begin
        Q0 <= rd_a;
        Q1 <= rd_b;
      end
      QV <= RE;
    end
endmodule

// File: doc/regfile_8x64_rd.md
Name: regfile_8x64_rd

Overview:
- 8-entry x 64-bit register file with one synchronous write port and two registered read ports (A and B).
- Upstream of the decode/execute boundary; its read outputs are the ID/EX operand registers.
- Provides write-to-read bypass, stall hold, flush and an asynchronous debug readback port for the software register interface.

Parameters:
- DW, 64, data width. Fixed at 64 for this CPU; kept as a parameter for the bench only.
- ZERO_R0, 1, when 1 register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- WE  in  1  write enable
- WA  in  3  write address
- WD  in  64  write data
- RE  in  1  read request; operands captured this cycle are valid next cycle
- RA0  in  3  read address, port A
- RA1  in  3  read address, port B
- STALL  in  1  hold the read outputs and QV
- FLUSH  in  1  squash the read outputs
- Q0  out  64  registered port-A operand
- Q1  out  64  registered port-B operand
- QV  out  1  Q0/Q1 valid
- DBG_A  in  3  debug read address
- DBG_Q  out  64  combinational debug read of the array; no bypass

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - all 8 registers = 0
  - Q0 = 0, Q1 = 0, QV = 0
- Deasserting reset mid-operation discards any in-flight read. The first capture occurs on the first edge after deassertion.
- Write, at a rising edge:
  - if WE=1, reg[WA] <= WD
  - if ZERO_R0=1 and WA=0, the write is dropped
  - writes are unaffected by STALL and FLUSH
- Read capture, priority FLUSH > STALL > RE, at a rising edge:
  - FLUSH=1: Q0 <= 0, Q1 <= 0, QV <= 0
  - else STALL=1: Q0, Q1 and QV hold
  - else RE=1: Q0 <= rd(RA0), Q1 <= rd(RA1), QV <= 1
  - else: Q0, Q1 hold; QV <= 0
- Definition of rd(a):
  - 0 if ZERO_R0=1 and a=0
  - else WD if WE=1 and WA=a (same-edge bypass)
  - else reg[a]
- Latency: operands appear 1 cycle after the RE edge. The bypass makes a write performed on edge N visible to a read captured on edge N.
- Both ports may address the same register; both then receive the same value, including the bypass value.
- Bypass does not apply to a held (STALL) output. If a write lands during a stall, Q0/Q1 keep the stale value. The pipeline controller must not stall across a RAW hazard, or must re-issue the read.
- DBG_Q = reg[DBG_A] (0 for address 0 when ZERO_R0=1). It reflects the array after the write edge, with no bypass.
- Address inputs are 3 bits wide, so there are no out-of-range addresses and no wrap-around case.
- X or unknown select: no requirement beyond simulation-only assertions.

Decomposition:
- Shared package/header (cpu_defs):
  - REG_AW=3
  - REG_N=8
  - DW=64
  - REG_ZERO=3'd0
- Natural sub-module: mux8_to_1_x64, instantiated 3 times (port A, port B, debug). It sits after the bypass compare for A and B, and takes raw storage for debug.
- Storage and bypass logic stay in this module.

Test Plan:
- Reset assertion:
  - stimulus: write 64'hDEAD_BEEF_0000_0001 to r3, then assert reset mid-cycle without a clock edge
  - required: Q0=Q1=0, QV=0 and DBG_Q(r3)=0 immediately (asynchronous)
- Write then read:
  - stimulus: write r5=64'h0123_4567_89AB_CDEF at edge 1; at edge 2 read RA0=5, RA1=0 with RE=1
  - required: after edge 2, Q0=64'h0123_4567_89AB_CDEF, Q1=0, QV=1
- Same-edge bypass:
  - stimulus: WE=1, WA=2, WD=64'h55, RE=1, RA0=RA1=2 on the same edge
  - required: Q0=Q1=64'h55 after that edge; DBG_Q(2)=64'h55
- Zero register:
  - stimulus: WE=1, WA=0, WD=64'hFFFF_FFFF_FFFF_FFFF, RE=1, RA0=0
  - required: Q0=0 and DBG_Q(0)=0
- Stall/flush priority:
  - stimulus: load Q0=64'h11; then STALL=1 with RE=1, RA0 pointing at r7=64'h77
  - required: Q0 stays 64'h11, QV stays 1
  - stimulus: then FLUSH=1 and STALL=1 together
  - required: Q0=0, QV=0
- RE low:
  - stimulus: valid capture, then RE=0 for 2 cycles
  - required: QV=0 after the first edge, Q0/Q1 unchanged
